// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - frames NUM_TERMS unsigned products into an ACC_W-bit sum
// Define PRODUCT_ACC_SATURATE_EN to clamp the sum to all-ones on carry instead of wrapping.
module product_accumulator #(
   parameter int NUM_TERMS = 16,
   parameter int ACC_W     = 36
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      in_product,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [7:0]       out_count,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [7:0] LAST_M1 = 8'(NUM_TERMS - 1);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [7:0]       count;
   logic             ovf;
   logic             rdy;
   logic             vld;
   logic [ACC_W:0]   sum_ext;
   logic             carry;
   logic             xfer;

   assign sum_ext = {1'b0, acc} + {{(ACC_W - 31){1'b0}}, in_product};
   assign carry   = sum_ext[ACC_W];
   assign xfer    = in_valid & rdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
         vld   <= 1'b0;
         rdy   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  acc   <= {{(ACC_W - 32){1'b0}}, in_product};
                  count <= 8'd1;
                  ovf   <= 1'b0;
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (xfer) begin
                  count <= count + 8'd1;
                  if (carry)
                     ovf <= 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
                  // once clamped, any further nonzero add carries again, so the sum stays pinned
                  acc <= carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
                  acc <= sum_ext[ACC_W-1:0];
`endif
                  if (count == LAST_M1) begin
                     state <= DONE;
                     vld   <= 1'b1;
                     rdy   <= 1'b0;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
                  vld   <= 1'b0;
                  rdy   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = rdy;
   assign out_valid = vld;
   assign out_sum   = acc;
   assign out_count = count;
   assign overflow  = ovf;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter: NUM_TERMS, 16, number of products summed per frame; legal range 2..255.
REQ-002 Parameter: ACC_W, 36, accumulator and out_sum width in bits; legal range 33..48.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  in_product carries a valid product from the upstream Multiplier stage.
REQ-006 Port: in_product  input  32  unsigned product (Multiplier outProduct).
REQ-007 Port: in_ready  output  1  block accepts in_product this cycle.
REQ-008 Port: out_valid  output  1  out_sum/out_count/overflow hold a completed frame.
REQ-009 Port: out_ready  input  1  downstream consumes the result.
REQ-010 Port: out_sum  output  ACC_W  unsigned sum of the frame's products.
REQ-011 Port: out_count  output  8  number of products summed (equals NUM_TERMS when out_valid=1).
REQ-012 Port: overflow  output  1  sticky per-frame flag: a carry beyond ACC_W bits occurred.

Function
REQ-013 The block SHALL be an FSM with states IDLE, ACCUM and DONE, registered outputs only.
REQ-014 A transfer SHALL occur on a cycle where in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-015 IDLE, on transfer: acc <= zero-extended in_product, count <= 1, overflow <= 0, go to ACCUM.
REQ-016 ACCUM, on transfer: acc <= acc + in_product (unsigned, ACC_W+1-bit intermediate), count <= count+1.
REQ-017 ACCUM: when the transfer makes count equal NUM_TERMS, go to DONE; out_valid SHALL rise the cycle after the NUM_TERMS-th transfer.
REQ-018 Cycles with in_valid=0 SHALL leave acc, count and state unchanged (gaps allowed anywhere).
REQ-019 DONE: out_valid=1; out_sum, out_count, overflow SHALL stay stable until out_valid=1 and out_ready=1, then go to IDLE the next cycle with out_valid=0.
REQ-020 In DONE, in_product SHALL be ignored regardless of in_valid; exactly one bubble cycle separates back-to-back frames.
REQ-021 out_sum and out_count SHALL present the live acc and count in all states; only out_valid qualifies them.
REQ-022 Carry out of bit ACC_W-1 on any add SHALL set overflow for the rest of the frame.

Reset
REQ-023 reset=1 at a clock edge SHALL force state IDLE, acc=0, count=0, out_valid=0, overflow=0, in_ready=1 from the next cycle, in any state, including mid-frame or DONE.
REQ-024 reset SHALL take priority over a simultaneous transfer or out_ready handshake; the partial frame is discarded.

Configuration
REQ-025 Macro PRODUCT_ACC_SATURATE_EN defined: on carry, acc SHALL clamp to all-ones and remain all-ones for the frame; overflow set.
REQ-026 Macro PRODUCT_ACC_SATURATE_EN undefined: acc SHALL wrap modulo 2^ACC_W; overflow still set per REQ-022.

Verification
REQ-027 NUM_TERMS=4, out_ready=1, products 30,56,30,56 on consecutive cycles -> out_valid=1 one cycle after 4th transfer, out_sum=172, out_count=4, overflow=0.
REQ-028 Same frame, out_ready=0 for 10 cycles -> out_valid, out_sum=172 and in_ready=0 held stable; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-029 NUM_TERMS=4, products 6,7,8,9 with 3-cycle in_valid gaps between each -> out_sum=30, out_count=4.
REQ-030 NUM_TERMS=4, two products 100,200 accepted, then reset=1 one cycle -> all outputs reset; next frame 1,2,3,4 -> out_sum=10.
REQ-031 ACC_W=33, NUM_TERMS=4, four products 32'hFFFF_FFFF -> with macro out_sum=33'h1_FFFF_FFFF, overflow=1; without macro out_sum=33'h1_FFFF_FFFC, overflow=1.
REQ-032 NUM_TERMS=2, in_valid held 1 with products 5,5,5,5, out_ready=1 -> two results out_sum=10, one in_ready=0 bubble cycle between frames, no product lost.
